// File: rtl/sinc_tap_sequencer.sv
// sinc_tap_sequencer: steps the sinc evaluator through tap angles and buffers the captured FIR taps.
// Define SINC_SEQ_SYMMETRY_EN to evaluate only the first half of the taps and mirror each result.
module sinc_tap_sequencer #(
   parameter int N_TAPS        = 32,
   parameter int IN_WIDTH      = 24,
   parameter int N_STAGES      = 3,
   parameter int K             = 2**N_STAGES,
   parameter int SETTLE_CYCLES = 2*K+3
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic signed [IN_WIDTH-1:0] i_step,
   output logic                       o_busy,
   output logic                       o_done,
   output logic signed [IN_WIDTH-1:0] o_theta,
   input  logic signed [IN_WIDTH-1:0] i_sinc,
   output logic                       o_coef_valid,
   output logic [$clog2(N_TAPS)-1:0]  o_coef_idx,
   output logic signed [IN_WIDTH-1:0] o_coef_data,
   output logic                       o_sat,
   input  logic [$clog2(N_TAPS)-1:0]  i_rd_addr,
   output logic signed [IN_WIDTH-1:0] o_rd_data
);
   localparam int NW = $clog2(N_TAPS);
   localparam int CW = NW + 2;
   localparam int PW = CW + IN_WIDTH;
   localparam int TW = $clog2(SETTLE_CYCLES + 1);
`ifdef SINC_SEQ_SYMMETRY_EN
   localparam int  LAST     = (N_TAPS + 1) / 2 - 1;
   localparam logic SYM     = 1'b1;
`else
   localparam int  LAST     = N_TAPS - 1;
   localparam logic SYM     = 1'b0;
`endif
   localparam logic signed [CW-1:0] C_OFF = CW'(N_TAPS - 1);
   localparam logic signed [PW-1:0] MAX_V = PW'(2**(IN_WIDTH-1) - 1);
   localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, MIRROR, DONE} state_t;

   state_t                     state_q;
   logic [NW-1:0]              n_q, idx_q, mir, wr_addr;
   logic [TW-1:0]              cnt_q;
   logic signed [IN_WIDTH-1:0] step_q, theta_q, data_q, rd_q, theta_d, wr_data;
   logic signed [CW-1:0]       c_d;
   logic signed [PW-1:0]       prod_d;
   logic                       busy_q, done_q, cv_q, sat_q, sat_d, wr_en, need_mir, adv;
   logic [IN_WIDTH-1:0]        mem_q [N_TAPS];

   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_theta      = theta_q;
   assign o_coef_valid = cv_q;
   assign o_coef_idx   = idx_q;
   assign o_coef_data  = data_q;
   assign o_sat        = sat_q;
   assign o_rd_data    = rd_q;

   // theta = (2n - (N_TAPS-1)) * step / 2, formed at full width then clamped
   always_comb begin
      c_d      = $signed({1'b0, n_q, 1'b0}) - C_OFF;
      prod_d   = (PW'(c_d) * PW'(step_q)) >>> 1;
      sat_d    = (prod_d > MAX_V) || (prod_d < MIN_V);
      theta_d  = prod_d > MAX_V ? MAX_V[IN_WIDTH-1:0] :
                 prod_d < MIN_V ? MIN_V[IN_WIDTH-1:0] : prod_d[IN_WIDTH-1:0];
      mir      = NW'(N_TAPS - 1) - n_q;
      need_mir = SYM && (mir != n_q);
      wr_en    = (state_q == CAPTURE) || (state_q == MIRROR);
      wr_addr  = state_q == MIRROR ? mir : n_q;
      wr_data  = state_q == MIRROR ? data_q : i_sinc;
      adv      = (state_q == CAPTURE && !need_mir) || state_q == MIRROR;
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         step_q  <= '0;
         theta_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cv_q    <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         sat_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         cv_q   <= wr_en;
         done_q <= 1'b0;
         rd_q   <= mem_q[i_rd_addr];
         if (wr_en) begin
            idx_q  <= wr_addr;
            data_q <= wr_data;
         end
         case (state_q)
            IDLE: if (i_start) begin
               step_q  <= i_step;
               n_q     <= '0;
               sat_q   <= 1'b0;
               busy_q  <= 1'b1;
               state_q <= LOAD;
            end
            LOAD: begin
               theta_q <= theta_d;
               sat_q   <= sat_q | sat_d;
               cnt_q   <= '0;
               state_q <= SETTLE;
            end
            SETTLE: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == TW'(SETTLE_CYCLES - 1)) state_q <= CAPTURE;
            end
            CAPTURE: state_q <= MIRROR;
            default: state_q <= IDLE;
         endcase
         if (adv) begin
            if (n_q == NW'(LAST)) begin
               state_q <= DONE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end else begin
               n_q     <= n_q + 1'b1;
               state_q <= LOAD;
            end
         end
      end
   end
endmodule

// File: tb/tb_sinc_tap_sequencer.sv
// tb_sinc_tap_sequencer: scoreboard bench with a delayed-response evaluator stub on two instances.
module tb_sinc_tap_sequencer;
   localparam int S = 19;
   typedef struct packed {logic [31:0] idx; logic [23:0] th; logic [23:0] d;} exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, start_a, busy_a, done_a, cv_a, sat_a;
   logic [23:0] step_a, theta_a, sinc_a, data_a, rdd_a;
   logic [4:0]  idx_a, rda_a;
   logic        rst_b, start_b, busy_b, done_b, cv_b, sat_b;
   logic [23:0] step_b, theta_b, sinc_b, data_b, rdd_b;
   logic [2:0]  idx_b, rda_b;

   int errors = 0;
   int checks = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic [23:0] ma [32];
   logic [23:0] mb [5];
   logic [23:0] pa [16];
   logic [23:0] pb [16];

   sinc_tap_sequencer #(.N_TAPS(32)) u_a (
      .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_step(step_a), .o_busy(busy_a),
      .o_done(done_a), .o_theta(theta_a), .i_sinc(sinc_a), .o_coef_valid(cv_a),
      .o_coef_idx(idx_a), .o_coef_data(data_a), .o_sat(sat_a), .i_rd_addr(rda_a), .o_rd_data(rdd_a));

   sinc_tap_sequencer #(.N_TAPS(5)) u_b (
      .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_step(step_b), .o_busy(busy_b),
      .o_done(done_b), .o_theta(theta_b), .i_sinc(sinc_b), .o_coef_valid(cv_b),
      .o_coef_idx(idx_b), .o_coef_data(data_b), .o_sat(sat_b), .i_rd_addr(rda_b), .o_rd_data(rdd_b));

   function automatic logic [23:0] m_sinc(input logic [23:0] t);
      int a;
      a = int'($signed(t));
      if (a < 0) a = -a;
      return 24'(32'h400000 - 32'(a >> 2));
   endfunction

   function automatic logic [23:0] m_theta(input int n, input int nt, input logic [23:0] st, output bit sat);
      longint p;
      p = (longint'(2 * n - (nt - 1)) * longint'($signed(st))) >>> 1;
      sat = (p > 64'sd8388607) || (p < -64'sd8388608);
      if (p > 64'sd8388607) p = 64'sd8388607;
      if (p < -64'sd8388608) p = -64'sd8388608;
      return 24'(p);
   endfunction

   // evaluator stub: result follows the angle after 16 cycles, inside the settle window
   always @(posedge clk) begin
      pa[0] <= m_sinc(theta_a);
      pb[0] <= m_sinc(theta_b);
      for (int i = 1; i < 16; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end
   assign sinc_a = pa[15];
   assign sinc_b = pb[15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (cv_a) begin
         if (qa.size() == 0) chk("a_extra_valid", 32'(cv_a), 32'd0);
         else begin
            e = qa.pop_front();
            chk("a_idx", 32'(idx_a), e.idx);
            chk("a_theta", 32'(theta_a), 32'(e.th));
            chk("a_data", 32'(data_a), 32'(e.d));
            ma[e.idx[4:0]] = e.d;
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (cv_b) begin
         if (qb.size() == 0) chk("b_extra_valid", 32'(cv_b), 32'd0);
         else begin
            e = qb.pop_front();
            chk("b_idx", 32'(idx_b), e.idx);
            chk("b_theta", 32'(theta_b), 32'(e.th));
            chk("b_data", 32'(data_b), 32'(e.d));
            mb[e.idx[2:0]] = e.d;
         end
      end
   end

   task automatic push_run(input bit w, input logic [23:0] st, output int lat, output bit sx);
      int nt, ne;
      bit s;
      logic [23:0] th;
      nt = w ? 5 : 32;
      ne = nt;
`ifdef SINC_SEQ_SYMMETRY_EN
      ne = (nt + 1) / 2;
`endif
      lat = 1;
      sx = 1'b0;
      for (int n = 0; n < ne; n++) begin
         th = m_theta(n, nt, st, s);
         sx |= s;
         lat += S + 2;
         if (w) qb.push_back('{32'(n), th, m_sinc(th)});
         else qa.push_back('{32'(n), th, m_sinc(th)});
`ifdef SINC_SEQ_SYMMETRY_EN
         if (nt - 1 - n != n) begin
            lat++;
            if (w) qb.push_back('{32'(nt - 1 - n), th, m_sinc(th)});
            else qa.push_back('{32'(nt - 1 - n), th, m_sinc(th)});
         end
`endif
      end
   endtask

   task automatic run(input bit w, input logic [23:0] st, input bit extra);
      int lat, cyc;
      bit sx, got;
      push_run(w, st, lat, sx);
      @(negedge clk);
      if (w) begin start_b = 1'b1; step_b = st; end
      else begin start_a = 1'b1; step_a = st; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      step_a = ~st;
      step_b = ~st;
      chk("sat_clr", 32'(w ? sat_b : sat_a), 32'd0);
      chk("busy_on", 32'(w ? busy_b : busy_a), 32'd1);
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < lat + 50) begin
         if (w ? done_b : done_a) got = 1'b1;
         else begin
            if (!w) start_a = extra && (cyc == 100);
            @(negedge clk);
            cyc++;
         end
      end
      chk("done_lat", got ? 32'(cyc) : 32'hFFFFFFFF, 32'(lat));
      chk("busy_off", 32'(w ? busy_b : busy_a), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(w ? done_b : done_a), 32'd0);
      chk("sat", 32'(w ? sat_b : sat_a), 32'(sx));
      chk("q_empty", 32'(w ? qb.size() : qa.size()), 32'd0);
   endtask

   task automatic readback(input bit w);
      for (int i = 0; i < (w ? 5 : 32); i++) begin
         @(negedge clk);
         if (w) rda_b = 3'(i);
         else rda_a = 5'(i);
         @(negedge clk);
         chk("rd_data", 32'(w ? rdd_b : rdd_a), 32'(w ? mb[i] : ma[i]));
      end
   endtask

   initial begin
      int cyc, seen, lat;
      bit sx;
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      step_a = '0; step_b = '0; rda_a = '0; rda_b = '0;
      repeat (20) @(negedge clk);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_theta", 32'(theta_a), 32'd0);
      chk("rst_valid", 32'(cv_a), 32'd0);
      chk("rst_idx", 32'(idx_a), 32'd0);
      chk("rst_data", 32'(data_a), 32'd0);
      chk("rst_sat", 32'(sat_a), 32'd0);
      chk("rst_rd", 32'(rdd_a), 32'd0);
      chk("rst_b_theta", 32'(theta_b), 32'd0);
      chk("rst_b_busy", 32'(busy_b), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      run(1'b0, 24'h000000, 1'b0);
      readback(1'b0);
      run(1'b1, 24'h100000, 1'b0);
      readback(1'b1);
      run(1'b0, 24'h3FFFFF, 1'b0);
      run(1'b0, 24'h100000, 1'b1);
      readback(1'b0);
      push_run(1'b0, 24'h100000, lat, sx);
      @(negedge clk);
      start_a = 1'b1;
      step_a = 24'h100000;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 0;
      while (!(cv_a && idx_a == 5'd9) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("tap9_seen", 32'(cyc < 2000), 32'd1);
      repeat (4) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      qa.delete();
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_theta", 32'(theta_a), 32'd0);
      chk("mid_rst_done", 32'(done_a), 32'd0);
      seen = 0;
      repeat (800) begin
         @(negedge clk);
         if (done_a) seen++;
      end
      chk("no_done_after_rst", 32'(seen), 32'd0);
      run(1'b0, 24'h080000, 1'b0);
      readback(1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sinc_tap_sequencer.md
# sinc_tap_sequencer

Drives the `sinc` evaluator to build a table of windowless sinc FIR taps. On a start pulse it steps tap index n = 0..N_TAPS-1 and presents θ_n = (n − (N_TAPS−1)/2)·step on the evaluator's angle input. It holds each angle until the free-running evaluator has produced a settled result, then captures `o_sinc` into a coefficient buffer and streams it out. It sits between the filter-design control registers (upstream) and the FIR coefficient loader (downstream).

## Interface
Parameters:
- `N_TAPS`, 32: number of taps; must be ≥2 and ≤256.
- `IN_WIDTH`, `AUDIO_WIDTH` (24): Q2.22 sample/angle width.
- `K`, 2**`N_STAGES`: evaluator frame length in cycles.
- `SETTLE_CYCLES`, 2*K+3: hold time per angle before capture; must be ≥2*K+3.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_start`, in, 1: one-cycle start pulse; ignored unless idle.
- `i_step`, in, IN_WIDTH: signed Q2.22 angle increment per tap; sampled on the accepted start.
- `o_busy`, out, 1: high from the cycle after an accepted start until done.
- `o_done`, out, 1: one-cycle pulse after the last tap is written.
- `o_theta`, out, IN_WIDTH: signed Q2.22 angle; connects to `sinc.i_theta`.
- `i_sinc`, in, IN_WIDTH: signed Q2.22 result from `sinc.o_sinc`.
- `o_coef_valid`, out, 1: one-cycle strobe per captured tap.
- `o_coef_idx`, out, $clog2(N_TAPS): tap index of `o_coef_data`.
- `o_coef_data`, out, IN_WIDTH: captured coefficient.
- `o_sat`, out, 1: sticky flag; set if any θ saturated during the run; cleared on accepted start.
- `i_rd_addr`, in, $clog2(N_TAPS): buffer read address.
- `o_rd_data`, out, IN_WIDTH: buffer read data, registered.

## Operation
- State machine: IDLE → LOAD → SETTLE → CAPTURE → (LOAD | DONE) → IDLE.
- **IDLE:** waits for `i_start`. On start it latches `i_step`, sets n=0, clears `o_sat` and goes to LOAD.
- **LOAD:** computes θ_n and registers it to `o_theta`, then goes to SETTLE with the hold counter at 0.
- **SETTLE:** counts to SETTLE_CYCLES−1. `o_theta` stays stable throughout.
- **CAPTURE:** writes `i_sinc` to buffer[n] and pulses `o_coef_valid` with idx n. It then increments n and goes to LOAD, or goes to DONE after the last tap.
- **DONE:** pulses `o_done` for one cycle and drops `o_busy`.
- **Angle arithmetic:**
  - Computed as c = 2n − (N_TAPS−1), a signed integer of $clog2(N_TAPS)+2 bits.
  - The full product c·step is formed at full width (MULT_GROWTH_SIGNED), then shifted arithmetically right by 1.
  - The result saturates to the signed IN_WIDTH range; saturation sets `o_sat`.
  - Even N_TAPS therefore yields half-step offsets (±step/2, ±3step/2, ...).
- **Buffer:** N_TAPS×IN_WIDTH. There is one write port, internal to CAPTURE. The read port is synchronous and usable in any state. A same-cycle read of a location being written returns the old data.
- `i_start` while busy is ignored and has no effect on the run.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_theta`=0, `o_coef_valid`=0, `o_coef_idx`=0, `o_coef_data`=0, `o_sat`=0, `o_rd_data`=0.
- Buffer contents are not cleared by reset.
- Per-tap period is SETTLE_CYCLES+2 cycles (LOAD + SETTLE + CAPTURE).
- Total time from start pulse to `o_done` is 1 + N_TAPS·(SETTLE_CYCLES+2) cycles (symmetry off).
- `o_coef_valid` asserts in the same cycle the buffer write occurs. `o_rd_data` follows `i_rd_addr` by 1 cycle.
- Reset mid-run: the block returns to IDLE on the next edge and no `o_done` is issued. Partially written buffer entries remain.
- SETTLE_CYCLES ≥ 2K+3 guarantees that one complete evaluator frame starts and finishes after the angle change, regardless of the evaluator's free-running phase.

## Configuration
- `SINC_SEQ_SYMMETRY_EN`:
  - **Defined:** only taps n = 0..⌈N_TAPS/2⌉−1 are evaluated. Each CAPTURE writes buffer[n] and buffer[N_TAPS−1−n] on consecutive cycles; the second write adds one cycle to CAPTURE, except at the centre tap when N_TAPS is odd. `o_coef_valid` pulses once per written index, and the mirror is emitted second. The run takes about half the time.
  - **Undefined:** every tap is evaluated independently, as described in Operation.

## Test plan
- `i_step`=0, N_TAPS=32, start → all 32 `o_coef_data` = 0x400000 ±16 LSB; `o_done` exactly 1+32·(SETTLE_CYCLES+2) cycles after start; `o_sat`=0.
- `i_step`=0x100000 (0.25), N_TAPS=5 → `o_theta` sequence −0x200000, −0x100000, 0, 0x100000, 0x200000; captured taps symmetric within ±16 LSB; centre tap = 0x400000.
- `i_step`=0x3FFFFF, N_TAPS=32 → outer taps' θ clamp to 0x7FFFFF/0x800000; `o_sat`=1 after the run; cleared by the next start.
- `i_start` pulsed again mid-run → ignored; tap count, `o_done` timing and buffer contents are identical to a single-start run.
- `i_rst`=1 during SETTLE of tap 10 → next cycle `o_busy`=0, `o_theta`=0, no `o_done`; a new start then completes normally.
- With `SINC_SEQ_SYMMETRY_EN`, N_TAPS=7, `i_step`=0x080000 → 4 evaluations, 7 `o_coef_valid` pulses; buffer[k] == buffer[6−k] bit-exact; read-back via `i_rd_addr` matches with 1-cycle latency.
